// File: rtl/regsel_pkg.sv
// Shared types and constants for the one-hot register-select issue logic.
package regsel_pkg;
    localparam int NREGS    = 32;
    localparam int REGIDX_W = 5;

    typedef logic [NREGS-1:0]    regsel_t;
    typedef logic [REGIDX_W-1:0] regidx_t;

    localparam regsel_t R0_ONEHOT = 32'h1;
endpackage

// File: rtl/reg_decoder5to32.sv
// Combinational 5-bit index to 32-bit one-hot register select.
module reg_decoder5to32
    import regsel_pkg::*;
(
    input  regidx_t i_idx,
    output regsel_t o_sel
);
    always_comb begin
        o_sel = R0_ONEHOT << i_idx;
    end
endmodule

// File: rtl/regsel_issue.sv
// Issue side of the one-hot register file: read selects, a delayed write select aligned
// with writeback, and a RAW interlock enabled by defining REGSEL_HAZARD_DETECT_EN.
module regsel_issue
    import regsel_pkg::*;
#(
    parameter int WB_LATENCY = 3,
    parameter int NREGS      = 32
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    issue_valid,
    input  regidx_t rs,
    input  regidx_t rt,
    input  regidx_t rd,
    input  logic    reg_write,
    input  logic    flush,
    output logic    issue_ready,
    output regsel_t Aselect,
    output regsel_t Bselect,
    output regsel_t Dselect,
    output logic    wb_valid,
    output regsel_t pending,
    output logic    hazard
);
    localparam int LAST = WB_LATENCY - 1;

    regsel_t           w_rs_oh;
    regsel_t           w_rt_oh;
    regsel_t           w_rd_oh;
    regsel_t           w_wr_oh;
    regsel_t           w_pending;
    logic              w_hazard;
    logic              w_accept;

    regsel_t           r_aselect;
    regsel_t           r_bselect;
    logic [NREGS-1:0]  r_d_pipe [WB_LATENCY];

    reg_decoder5to32 u_dec_rs (.i_idx(rs), .o_sel(w_rs_oh));
    reg_decoder5to32 u_dec_rt (.i_idx(rt), .o_sel(w_rt_oh));
    reg_decoder5to32 u_dec_rd (.i_idx(rd), .o_sel(w_rd_oh));

    // The last stage is left out: it commits before a newly registered read select is used.
    always_comb begin
        w_pending = '0;
        for (int k = 0; k < WB_LATENCY - 1; k++) begin
            w_pending = w_pending | r_d_pipe[k];
        end
    end

`ifdef REGSEL_HAZARD_DETECT_EN
    assign w_hazard = issue_valid &&
                      (((w_rs_oh | w_rt_oh) & w_pending & ~R0_ONEHOT) != '0);
`else
    assign w_hazard = 1'b0;
`endif

    assign w_accept = issue_valid && !w_hazard && !flush;
    assign w_wr_oh  = (reg_write && (rd != '0)) ? w_rd_oh : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aselect <= R0_ONEHOT;
            r_bselect <= R0_ONEHOT;
            for (int k = 0; k < WB_LATENCY; k++) begin
                r_d_pipe[k] <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < WB_LATENCY; k++) begin
                r_d_pipe[k] <= '0;
            end
        end else begin
            for (int k = 1; k < WB_LATENCY; k++) begin
                r_d_pipe[k] <= r_d_pipe[k-1];
            end
            r_d_pipe[0] <= w_accept ? w_wr_oh : '0;
            if (w_accept) begin
                r_aselect <= w_rs_oh;
                r_bselect <= w_rt_oh;
            end
        end
    end

    assign Aselect     = r_aselect;
    assign Bselect     = r_bselect;
    assign Dselect     = r_d_pipe[LAST];
    assign wb_valid    = |r_d_pipe[LAST];
    assign pending     = w_pending;
    assign hazard      = w_hazard;
    assign issue_ready = !w_hazard;
endmodule

// File: tb/tb_regsel_issue.sv
// Directed bench for regsel_issue: a scheduled-writeback model checked every cycle plus
// literal expectations for each scenario. Follows REGSEL_HAZARD_DETECT_EN if defined.
module tb_regsel_issue;
    localparam int WBL = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  rs = '0;
    logic [4:0]  rt = '0;
    logic [4:0]  rd = '0;
    logic        reg_write = 1'b0;
    logic        flush = 1'b0;
    logic        issue_ready;
    logic [31:0] Aselect;
    logic [31:0] Bselect;
    logic [31:0] Dselect;
    logic        wb_valid;
    logic [31:0] pending;
    logic        hazard;

    int errs   = 0;
    int checks = 0;

    regsel_issue #(.WB_LATENCY(WBL), .NREGS(32)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
        .rs(rs), .rt(rt), .rd(rd), .reg_write(reg_write), .flush(flush),
        .issue_ready(issue_ready), .Aselect(Aselect), .Bselect(Bselect),
        .Dselect(Dselect), .wb_valid(wb_valid), .pending(pending), .hazard(hazard)
    );

    always #5 clk = ~clk;

    // Model: each accepted write is a record of (cycle it appears on Dselect, register).
    typedef struct {
        int         c;
        logic [4:0] r;
    } wr_t;

    wr_t         q[$];
    logic [31:0] m_a = 32'h1;
    logic [31:0] m_b = 32'h1;
    int          cyc = 0;

    function automatic logic [31:0] oh(input logic [4:0] i);
        return 32'h1 << i;
    endfunction

    function automatic logic [31:0] m_pending();
        logic [31:0] p = '0;
        foreach (q[i]) if (q[i].c > cyc) p |= oh(q[i].r);
        return p;
    endfunction

    function automatic logic [31:0] m_dsel();
        logic [31:0] d = '0;
        foreach (q[i]) if (q[i].c == cyc) d |= oh(q[i].r);
        return d;
    endfunction

    function automatic logic m_hazard();
`ifdef REGSEL_HAZARD_DETECT_EN
        return issue_valid && (((oh(rs) | oh(rt)) & m_pending() & ~32'h1) != 0);
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        logic acc;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                m_a = 32'h1;
                m_b = 32'h1;
                cyc = 0;
            end else begin
                acc = issue_valid && !m_hazard() && !flush;
                cyc++;
                if (flush) begin
                    q.delete();
                end else if (acc) begin
                    m_a = oh(rs);
                    m_b = oh(rt);
                    if (reg_write && rd != 0) q.push_back('{cyc + WBL - 1, rd});
                end
                for (int i = q.size() - 1; i >= 0; i--) if (q[i].c < cyc) q.delete(i);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("Aselect", Aselect, m_a);
            chk("Bselect", Bselect, m_b);
            chk("Dselect", Dselect, m_dsel());
            chk("wb_valid", {31'b0, wb_valid}, {31'b0, m_dsel() != 0});
            chk("pending", pending, m_pending());
            chk("hazard", {31'b0, hazard}, {31'b0, m_hazard()});
            chk("issue_ready", {31'b0, issue_ready}, {31'b0, !m_hazard()});
        end
    end

    task automatic drive(input logic v, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic w, input logic f);
        issue_valid = v;
        rs = s;
        rt = t;
        rd = d;
        reg_write = w;
        flush = f;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1);
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_Aselect", Aselect, 32'h1);
        chk("rst_Bselect", Bselect, 32'h1);
        chk("rst_Dselect", Dselect, 32'h0);
        chk("rst_pending", pending, 32'h0);
        rst_n = 1'b1;
        step();

        // Simple write: rs=1, rt=2, rd=5
        drive(1, 1, 2, 5, 1, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("t2_Aselect", Aselect, 32'h2);
        chk("t2_Bselect", Bselect, 32'h4);
        chk("t2_D0", Dselect, 32'h0);
        step();
        chk("t2_D1", Dselect, 32'h0);
        step();
        chk("t2_D2", Dselect, 32'h20);
        chk("t2_wbv", {31'b0, wb_valid}, 32'h1);
        step();
        chk("t2_wbv_off", {31'b0, wb_valid}, 32'h0);
        step();

        // Reset mid-stream with rd=7 in flight
        drive(1, 3, 4, 7, 1, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_Aselect", Aselect, 32'h1);
        chk("t1_Bselect", Bselect, 32'h1);
        chk("t1_Dselect", Dselect, 32'h0);
        chk("t1_pending", pending, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1_no_wb", Dselect, 32'h0);
        end

        // RAW on r9
        drive(1, 0, 0, 9, 1, 0);
        step();
        drive(1, 9, 0, 0, 0, 0);
        #1;
`ifdef REGSEL_HAZARD_DETECT_EN
        chk("t3_haz0", {31'b0, hazard}, 32'h1);
        chk("t3_rdy0", {31'b0, issue_ready}, 32'h0);
        step();
        chk("t3_haz1", {31'b0, hazard}, 32'h1);
        chk("t3_rdy1", {31'b0, issue_ready}, 32'h0);
        step();
        chk("t3_rdy2", {31'b0, issue_ready}, 32'h1);
        chk("t3_D", Dselect, 32'h200);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("t3_Aselect", Aselect, 32'h200);
`else
        chk("t3_haz0", {31'b0, hazard}, 32'h0);
        chk("t3_rdy0", {31'b0, issue_ready}, 32'h1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("t3_Aselect", Aselect, 32'h200);
        step();
        chk("t3_D", Dselect, 32'h200);
`endif
        repeat (3) step();

        // Write to r0 is suppressed; reading r0 never interlocks
        drive(1, 0, 0, 0, 1, 0);
        step();
        drive(1, 0, 0, 0, 0, 0);
        #1;
        chk("t4_haz", {31'b0, hazard}, 32'h0);
        chk("t4_rdy", {31'b0, issue_ready}, 32'h1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("t4_wbv", {31'b0, wb_valid}, 32'h0);
            step();
        end

        // Flush with rd=3 and rd=4 in flight, plus a dropped issue of rd=6
        drive(1, 1, 2, 3, 1, 0);
        step();
        drive(1, 13, 2, 4, 1, 0);
        step();
        drive(1, 14, 15, 6, 1, 1);
        #1;
        chk("t5_pend_pre", pending, 32'h18);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("t5_pend", pending, 32'h0);
        chk("t5_Ahold", Aselect, 32'h2000);
        for (int i = 0; i < 4; i++) begin
            chk("t5_D", Dselect, 32'h0);
            step();
        end

        // Back-to-back independent writes
        for (int i = 10; i <= 12; i++) begin
            drive(1, 1, 2, 5'(i), 1, 0);
            #1;
            chk("t6_rdy", {31'b0, issue_ready}, 32'h1);
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("t6_D10", Dselect, 32'h400);
        step();
        chk("t6_D11", Dselect, 32'h800);
        step();
        chk("t6_D12", Dselect, 32'h1000);
        step();
        chk("t6_Doff", Dselect, 32'h0);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/regsel_issue.md
Name: regsel_issue

Overview:
- Initiator side of the one-hot register-file interface.
- Turns 5-bit instruction register fields (rs, rt, rd) into the one-hot Aselect/Bselect read selects and a pipelined one-hot Dselect write select.
- Dselect is time-aligned with dbus at writeback.
- Tracks in-flight destinations and interlocks issue on read-after-write hazards.
- Sits between instruction decode and the register file.

Parameters:
WB_LATENCY, 3, clock edges from accepted issue to Dselect assertion; legal range 1..8.
NREGS, 32, number of architectural registers; fixed at 32, and select width equals NREGS.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
issue_valid  input  1  instruction fields valid this cycle
rs  input  5  A-port source register index
rt  input  5  B-port source register index
rd  input  5  destination register index
reg_write  input  1  instruction writes rd
flush  input  1  synchronous kill of all in-flight writes
issue_ready  output  1  issue accepted this cycle when issue_valid && issue_ready
Aselect  output  32  one-hot A read select (registered)
Bselect  output  32  one-hot B read select (registered)
Dselect  output  32  one-hot write select, or all-zero for no write
wb_valid  output  1  Dselect non-zero this cycle
pending  output  32  OR of in-flight destinations in stages 0..WB_LATENCY-2
hazard  output  1  RAW conflict on the current request

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - Aselect = Bselect = 32'h0000_0001 (selects r0, which always reads zero, so the read buses never float).
  - All pipe stages = 0, Dselect = 0, wb_valid = 0, pending = 0.
- Pipeline:
  - Registers d_pipe[0..WB_LATENCY-1], each 32 bits.
  - Every edge shifts d_pipe[k] -> d_pipe[k+1].
  - Dselect = d_pipe[WB_LATENCY-1]; wb_valid = |Dselect.
- Accept: accept = issue_valid && issue_ready && !flush. On the accepting edge:
  - Aselect <= onehot(rs); Bselect <= onehot(rt).
  - d_pipe[0] <= (reg_write && rd != 0) ? onehot(rd) : 0.
  - Writes to r0 are suppressed entirely.
- No accept: d_pipe[0] <= 0 (bubble). Aselect/Bselect hold their last value.
- Latency:
  - Selects are valid in the cycle after accept.
  - Dselect is asserted exactly WB_LATENCY edges after accept, for one cycle.
- Flush:
  - All d_pipe stages clear to 0 on that edge, including the stage currently driving Dselect (next-cycle value).
  - Any issue in the same cycle is dropped.
  - Aselect/Bselect hold.
- pending: OR of d_pipe[0..WB_LATENCY-2]; constant 0 when WB_LATENCY = 1. The last stage is excluded because its write commits at the end of the current cycle, before the registered read select takes effect.
- Hazard: hazard = issue_valid && (((onehot(rs) | onehot(rt)) & pending & ~32'h1) != 0).
- issue_ready = !hazard (see Optional Feature).
- Simultaneous events: hazard and flush in the same cycle — flush wins; the next cycle sees pending = 0.
- Invariants:
  - Aselect and Bselect are always exactly one-hot.
  - Dselect is always one-hot or zero, and never has bit 0 set.

Optional Feature:
Macro: REGSEL_HAZARD_DETECT_EN
- Defined: hazard is computed as above, and issue_ready = !hazard (self-stall with bubble insertion).
- Undefined:
  - hazard is tied 0 and issue_ready is tied 1.
  - Software or a forwarding unit owns RAW correctness.
  - pending is still driven.

Decomposition:
- Package regsel_pkg holds:
  - NREGS = 32, REGIDX_W = 5.
  - R0_ONEHOT = 32'h1.
  - typedef regsel_t (logic [31:0]).
  - typedef regidx_t (logic [4:0]).
- Sub-module reg_decoder5to32: combinational 5-to-32 one-hot decoder, instantiated three times (rs, rt, rd).
- Pipeline, pending, and hazard logic stay in regsel_issue.

Test Plan:
1. Reset mid-stream: issue rd=7 with reg_write, then pulse rst_n low one cycle later -> Aselect = Bselect = 32'h1, Dselect = 0, pending = 0 immediately (asynchronous), and no later writeback.
2. Simple write: accept rs=1, rt=2, rd=5, reg_write=1 (WB_LATENCY=3) -> next cycle Aselect = 32'h2, Bselect = 32'h4; 3 edges after accept Dselect = 32'h20 and wb_valid = 1 for exactly one cycle.
3. RAW interlock (macro on):
   - Issue rd=9, then next cycle request rs=9.
   - Required: hazard = 1 and issue_ready = 0 for 2 cycles.
   - Accepted on the third cycle, in the same cycle Dselect = 32'h200.
   - With the macro off, the request is accepted immediately.
4. r0 destination: reg_write=1, rd=0 -> Dselect stays 0 and wb_valid never asserts. A following request with rs=0 has no hazard.
5. Flush: two writes in flight (rd=3, rd=4) plus flush asserted -> Dselect never shows 32'h8 or 32'h10, pending = 0 next cycle, and an issue in the flush cycle is dropped.
6. Back-to-back independent issues: rd=10, 11, 12 on consecutive cycles with no dependencies -> Dselect = 32'h400, 32'h800, 32'h1000 on consecutive cycles, and issue_ready stays 1 throughout.
